// File: rtl/exp5_unidade_controle_pkg.sv
// State codes and default timing for the play-round control unit.
package exp5_unidade_controle_pkg;

  localparam int TIMEOUT_DEF = 5000;

  localparam logic [3:0] S_INICIAL     = 4'h0;
  localparam logic [3:0] S_PREPARACAO  = 4'h1;
  localparam logic [3:0] S_ESPERA      = 4'h2;
  localparam logic [3:0] S_REGISTRA    = 4'h4;
  localparam logic [3:0] S_COMPARACAO  = 4'h5;
  localparam logic [3:0] S_PROXIMO     = 4'h6;
  localparam logic [3:0] S_FIM_ACERTOU = 4'hA;
  localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] S_FIM_ERROU   = 4'hE;

endpackage

// File: rtl/exp5_contador_timeout.sv
// Inactivity timer: counts while enabled, saturates at TIMEOUT-1 and flags it.
module exp5_contador_timeout #(
  parameter int TIMEOUT = 5000,
  parameter int TIMER_W = 13
) (
  input  logic clock,
  input  logic zera,
  input  logic conta,
  output logic fim_timeout
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

  assign fim_timeout = (cnt_q == LAST);

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control FSM for one play round: sequences counter, play register and
// comparator, and ends the round on mismatch, completion or inactivity timeout.
module exp5_unidade_controle
  import exp5_unidade_controle_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TIMER_W = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fim,
  input  logic       jogada,
  input  logic       igual,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       tmr_fim;

  // Timer only runs in espera, so every accepted move restarts the wait window.
  exp5_contador_timeout #(
    .TIMEOUT(TIMEOUT),
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clock      (clock),
    .zera       (reset || (state_q != S_ESPERA)),
    .conta      (state_q == S_ESPERA),
    .fim_timeout(tmr_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_INICIAL;
    case (state_q)
      S_INICIAL:    state_d = iniciar ? S_PREPARACAO : S_INICIAL;
      S_PREPARACAO: state_d = S_ESPERA;
      // A move arriving on the last wait cycle is still accepted.
      S_ESPERA: begin
        if (jogada) begin
          state_d = S_REGISTRA;
        end else if (tmr_fim) begin
          state_d = S_FIM_TIMEOUT;
        end else begin
          state_d = S_ESPERA;
        end
      end
      S_REGISTRA:   state_d = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!igual) begin
          state_d = S_FIM_ERROU;
        end else if (fim) begin
          state_d = S_FIM_ACERTOU;
        end else begin
          state_d = S_PROXIMO;
        end
      end
      S_PROXIMO:    state_d = S_ESPERA;
      S_FIM_ACERTOU,
      S_FIM_ERROU,
      S_FIM_TIMEOUT: state_d = iniciar ? S_PREPARACAO : state_q;
      default:      state_d = S_INICIAL;
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    zeraR     = 1'b0;
    contaC    = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    case (state_q)
      S_PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      S_REGISTRA:    registraR = 1'b1;
      S_PROXIMO:     contaC    = 1'b1;
      S_FIM_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      S_FIM_ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      S_FIM_TIMEOUT: begin
        errou   = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule
